// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants: fetch FSM states, NOP encoding,
// sequential PC step and the IF/ID payload struct.
package pipe_pkg;

    localparam int unsigned PIPE_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StHold
    } fetch_state_e;

    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] pc;
        logic [31:0]          instr;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer used while decode back-pressures a
// returning fetch response.
module fetch_skid_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    input  logic            unload,
    input  logic            clear,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (clear || unload) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= load_pc;
            instr_q <= load_instr;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: single-outstanding imem requests, IF/ID payload with
// skid buffer, redirect flush. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] PC_STEP   = pipe_pkg::PC_STEP,
    parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_d,
    output logic            pc_hold,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    if_id_t          if_q, if_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            redirect_act;
    logic            skid_load, skid_unload, skid_clear;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;

    // Redirects are meaningless before the first fetch, so IDLE ignores them.
    assign redirect_act = redirect_valid && (state_q != StIdle) && !rst;

    fetch_skid_buf #(
        .XLEN(XLEN)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .load_pc   (req_pc_q),
        .load_instr(imem_rdata),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .valid     (skid_valid),
        .pc        (skid_pc),
        .instr     (skid_instr)
    );

    always_comb begin
        state_d     = state_q;
        if_d        = if_q;
        drop_d      = drop_q;
        req_pc_d    = req_pc_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        imem_req    = 1'b0;
        pc_hold     = 1'b1;
        pc_d        = pc_q;

        if (if_q.valid && !id_stall) begin
            if_d.valid = 1'b0;
            if_d.instr = NOP_INSTR;
        end

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    pc_hold  = 1'b0;
                    pc_d     = pc_q + PC_STEP;
                    req_pc_d = pc_q;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StFetch;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!if_q.valid || !id_stall) begin
                        if_d.valid = 1'b1;
                        if_d.pc    = req_pc_q;
                        if_d.instr = imem_rdata;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                if (!id_stall && skid_valid) begin
                    if_d.valid  = 1'b1;
                    if_d.pc     = skid_pc;
                    if_d.instr  = skid_instr;
                    skid_unload = 1'b1;
                    state_d     = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_act) begin
            imem_req   = 1'b0;
            pc_hold    = 1'b0;
            pc_d       = redirect_pc;
            req_pc_d   = req_pc_q;
            if_d.valid = 1'b0;
            if_d.instr = NOP_INSTR;
            skid_load  = 1'b0;
            skid_unload = 1'b0;
            skid_clear = 1'b1;
            // A response still in flight must be swallowed when it arrives.
            if (state_q == StWait && !imem_rvalid) begin
                drop_d  = 1'b1;
                state_d = StWait;
            end else begin
                drop_d  = 1'b0;
                state_d = StFetch;
            end
        end

        if (rst) begin
            imem_req = 1'b0;
            pc_hold  = 1'b1;
            pc_d     = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            if_q.valid <= 1'b0;
            if_q.pc    <= '0;
            if_q.instr <= NOP_INSTR;
            drop_q     <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            state_q  <= state_d;
            if_q     <= if_d;
            drop_q   <= drop_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = if_q.valid;
    assign if_pc     = if_q.pc;
    assign if_instr  = if_q.instr;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_grant;
    assign fetch_grant = imem_req && imem_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_grant) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_act) perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (if_q.valid && id_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: behavioural PC register and imem, grant-time scoreboard
// checked on every IF/ID consumption, plus directed cycle checks.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q = '0;
    logic [31:0] pc_d;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int total = 0;
    int bad   = 0;

    logic        gnt_en;
    int          lat;
    logic        mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    logic        dut_out  = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    fetch_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .pc_q          (pc_q),
        .pc_d          (pc_d),
        .pc_hold       (pc_hold),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[27:0], 4'h7} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_if_valid"}, if_valid, 0);
        chk({tag, "_if_pc"}, if_pc, 0);
        chk({tag, "_if_instr"}, if_instr, NOP);
        chk({tag, "_imem_req"}, imem_req, 0);
        chk({tag, "_pc_hold"}, pc_hold, 1);
    endtask

    // PC register owned by the surrounding pipeline.
    always @(posedge clk) begin
        if (rst) pc_q <= '0;
        else if (!pc_hold) pc_q <= pc_d;
    end

    // Instruction memory: one request at a time, fixed latency chosen at grant.
    assign imem_gnt    = gnt_en && !mem_pend;
    assign imem_rvalid = mem_pend && (mem_cnt == 0);
    assign imem_rdata  = imem_rvalid ? instr_of(mem_addr) : 32'h0;

    always @(posedge clk) begin
        if (imem_rvalid) begin
            mem_pend <= 1'b0;
        end else if (mem_pend) begin
            mem_cnt <= mem_cnt - 1;
        end else if (imem_req && imem_gnt) begin
            mem_pend <= 1'b1;
            mem_cnt  <= lat - 1;
            mem_addr <= imem_addr;
        end
    end

    // Scoreboard: expect every granted fetch in order unless flushed by redirect/reset.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            dut_out = 1'b0;
        end else begin
            if (dut_out) chk("one_outstanding", imem_req, 0);
            if (if_valid && !id_stall && !redirect_valid) begin
                if (sb.size() == 0) begin
                    chk("if_spurious", if_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_if_pc", if_pc, e.pc);
                    chk("sb_if_instr", if_instr, e.instr);
                end
            end
            if (redirect_valid) sb.delete();
            if (imem_rvalid) dut_out = 1'b0;
            if (imem_req && imem_gnt) begin
                sb.push_back('{pc: imem_addr, instr: instr_of(imem_addr)});
                dut_out = 1'b1;
            end
        end
    end

    initial begin
        rst            = 1'b1;
        gnt_en         = 1'b1;
        lat            = 1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;

        tick();
        tick();
        sample();
        chk_reset_vals("rst0");

        // Cycle 0: release reset; first if_valid expected at cycle 3.
        tick(); rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            sample();
            chk("lat_if_valid", if_valid, (k == 3) ? 1 : 0);
            if (k == 1) chk("first_req", imem_req, 1);
        end

        // Cycles 5-8: decode stalled, payload frozen, response parks in skid.
        tick(); id_stall = 1'b1;
        sample();
        chk("stall_if_valid", if_valid, 1);
        chk("stall_if_pc", if_pc, 32'h4);
        for (int k = 6; k <= 8; k++) begin
            tick();
            sample();
            chk("stall_if_valid", if_valid, 1);
            chk("stall_if_pc", if_pc, 32'h4);
            if (k >= 7) chk("hold_no_req", imem_req, 0);
        end
        tick(); id_stall = 1'b0;
        sample();
        chk("hold_no_req", imem_req, 0);
        tick(); lat = 2;
        sample();
        chk("skid_if_pc", if_pc, 32'h8);
        chk("skid_if_valid", if_valid, 1);

        // Cycle 11: redirect in WAIT before the response returns.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        sample();
        chk("rdw_pc_hold", pc_hold, 0);
        chk("rdw_pc_d", pc_d, 32'h100);
        chk("rdw_req", imem_req, 0);
        tick(); redirect_valid = 1'b0; lat = 1;
        sample();
        chk("drop_if_valid", if_valid, 0);
        chk("drop_if_instr", if_instr, NOP);
        chk("drop_req", imem_req, 0);
        tick();
        sample();
        chk("tgt_req", imem_req, 1);
        chk("tgt_addr", imem_addr, 32'h100);
        tick();
        tick();
        sample();
        chk("tgt_if_pc", if_pc, 32'h100);
        chk("tgt_if_valid", if_valid, 1);

        // Cycle 16: redirect coinciding with rvalid.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        sample();
        chk("rdr_pc_d", pc_d, 32'h200);
        tick(); redirect_valid = 1'b0;
        sample();
        chk("rdr_if_valid", if_valid, 0);
        chk("rdr_if_instr", if_instr, NOP);
        chk("rdr_req", imem_req, 1);
        chk("rdr_addr", imem_addr, 32'h200);
        tick();
        tick(); id_stall = 1'b1;
        sample();
        chk("rdr_if_pc", if_pc, 32'h200);
        tick();

        // Cycle 21: redirect while HOLD with decode still stalled.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h300;
        sample();
        chk("rdh_req", imem_req, 0);
        chk("rdh_pc_hold", pc_hold, 0);
        chk("rdh_pc_d", pc_d, 32'h300);
        tick(); redirect_valid = 1'b0; id_stall = 1'b0;
        sample();
        chk("rdh_if_valid", if_valid, 0);
        chk("rdh_if_instr", if_instr, NOP);
        chk("rdh_req_next", imem_req, 1);
        chk("rdh_addr", imem_addr, 32'h300);
        tick();
        tick(); gnt_en = 1'b0;
        sample();
        chk("rdh_if_pc", if_pc, 32'h300);

        // Cycles 25-31: grant withheld at the top of the address space.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        for (int k = 26; k <= 30; k++) begin
            tick(); redirect_valid = 1'b0;
            sample();
            chk("nognt_req", imem_req, 1);
            chk("nognt_pc_hold", pc_hold, 1);
            chk("nognt_pc_q", pc_q, 32'hFFFF_FFFC);
        end
        tick(); gnt_en = 1'b1;
        sample();
        chk("wrap_pc_hold", pc_hold, 0);
        chk("wrap_pc_d", pc_d, 32'h0);
        tick();
        tick(); lat = 3;
        sample();
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        // Cycle 34: reset while WAIT; the slow response lands after reset.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; lat = 1;
        sample();
        chk_reset_vals("rstw");
        chk("rstw_pc_q", pc_q, 32'h0);
        tick();
        sample();
        chk("late_req", imem_req, 1);
        tick();
        sample();
        chk("late_if_valid", if_valid, 0);
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 32'h0);
        tick(); gnt_en = 1'b0;
        tick();
        sample();
        chk("restart_if_pc", if_pc, 32'h0);
        chk("restart_if_valid", if_valid, 1);
        tick();
        tick();
        sample();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
